// File: rtl/dmi_sba_loader.sv
// Streams word writes into target memory through the RISC-V debug System Bus
// Access registers over DMI, skipping SBAddress0 writes when addresses are contiguous.
module dmi_sba_loader #(
   parameter int PollInterval = 128,
   parameter int PollTimeout  = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic        flush_i,
   output logic        flush_done_o,
   output logic        err_o,
   input  logic        err_clr_i,
   output logic        dmi_req_valid_o,
   input  logic        dmi_req_ready_i,
   output logic [6:0]  dmi_req_addr_o,
   output logic [1:0]  dmi_req_op_o,
   output logic [31:0] dmi_req_data_o,
   input  logic        dmi_resp_valid_i,
   output logic        dmi_resp_ready_o,
   input  logic [31:0] dmi_resp_data_i,
   input  logic [1:0]  dmi_resp_resp_i
);

   localparam logic [6:0]  AddrSbcs    = 7'h38;
   localparam logic [6:0]  AddrSbAddr0 = 7'h39;
   localparam logic [6:0]  AddrSbData0 = 7'h3C;
   localparam logic [1:0]  OpRead      = 2'd1;
   localparam logic [1:0]  OpWrite     = 2'd2;
   localparam logic [31:0] SbcsCfg     = 32'h0005_0000;

   typedef enum logic [2:0] {IDLE, CFG, ADDR, DATA, POLL, ERR} state_e;

   state_e      state;
   logic        ready_en;
   logic        cfg_done;
   logic        flushing;
   logic [31:0] exp_addr;
   logic [31:0] cap_addr;
   logic [31:0] cap_data;
   logic [31:0] word_cnt;
   logic [31:0] poll_cnt;
   logic        resp_fire;
   logic        sbcs_fault;
   logic        sbcs_busy;
   logic        unused_resp;

   assign resp_fire   = dmi_resp_ready_o && dmi_resp_valid_i;
   assign sbcs_fault  = dmi_resp_data_i[22] || (dmi_resp_data_i[14:12] != 3'd0);
   assign sbcs_busy   = dmi_resp_data_i[21];
   assign unused_resp = ^{dmi_resp_data_i[31:23], dmi_resp_data_i[20:15], dmi_resp_data_i[11:0]};

   // ready_en keeps wr_ready_o low until the first clock after reset release
   assign wr_ready_o = ready_en && (state == IDLE) && !err_o && !flush_i;

   // Every transaction state launches its request on entry, then waits for the response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state            <= IDLE;
         ready_en         <= 1'b0;
         cfg_done         <= 1'b0;
         flushing         <= 1'b0;
         exp_addr         <= '0;
         cap_addr         <= '0;
         cap_data         <= '0;
         word_cnt         <= '0;
         poll_cnt         <= '0;
         flush_done_o     <= 1'b0;
         err_o            <= 1'b0;
         dmi_req_valid_o  <= 1'b0;
         dmi_req_addr_o   <= '0;
         dmi_req_op_o     <= '0;
         dmi_req_data_o   <= '0;
         dmi_resp_ready_o <= 1'b0;
      end else begin
         ready_en     <= 1'b1;
         flush_done_o <= 1'b0;
         if (dmi_req_valid_o && dmi_req_ready_i) begin
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b1;
         end
         if (resp_fire) begin
            dmi_resp_ready_o <= 1'b0;
         end

         if (resp_fire && (dmi_resp_resp_i != 2'd0)) begin
            state <= ERR;
            err_o <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (ready_en && flush_i) begin
                     flushing        <= 1'b1;
                     poll_cnt        <= '0;
                     state           <= POLL;
                     dmi_req_valid_o <= 1'b1;
                     dmi_req_addr_o  <= AddrSbcs;
                     dmi_req_op_o    <= OpRead;
                     dmi_req_data_o  <= '0;
                  end else if (wr_valid_i && wr_ready_o) begin
                     cap_addr        <= wr_addr_i;
                     cap_data        <= wr_data_i;
                     dmi_req_valid_o <= 1'b1;
                     dmi_req_op_o    <= OpWrite;
                     if (!cfg_done) begin
                        state          <= CFG;
                        dmi_req_addr_o <= AddrSbcs;
                        dmi_req_data_o <= SbcsCfg;
                     end else if (wr_addr_i == exp_addr) begin
                        state          <= DATA;
                        dmi_req_addr_o <= AddrSbData0;
                        dmi_req_data_o <= wr_data_i;
                     end else begin
                        state          <= ADDR;
                        dmi_req_addr_o <= AddrSbAddr0;
                        dmi_req_data_o <= wr_addr_i;
                     end
                  end
               end
               CFG: begin
                  if (resp_fire) begin
                     cfg_done        <= 1'b1;
                     state           <= ADDR;
                     dmi_req_valid_o <= 1'b1;
                     dmi_req_addr_o  <= AddrSbAddr0;
                     dmi_req_op_o    <= OpWrite;
                     dmi_req_data_o  <= cap_addr;
                  end
               end
               ADDR: begin
                  if (resp_fire) begin
                     state           <= DATA;
                     dmi_req_valid_o <= 1'b1;
                     dmi_req_addr_o  <= AddrSbData0;
                     dmi_req_op_o    <= OpWrite;
                     dmi_req_data_o  <= cap_data;
                  end
               end
               DATA: begin
                  if (resp_fire) begin
                     exp_addr <= cap_addr + 32'd4;
                     if (word_cnt + 32'd1 == 32'(PollInterval)) begin
                        word_cnt        <= '0;
                        flushing        <= 1'b0;
                        poll_cnt        <= '0;
                        state           <= POLL;
                        dmi_req_valid_o <= 1'b1;
                        dmi_req_addr_o  <= AddrSbcs;
                        dmi_req_op_o    <= OpRead;
                        dmi_req_data_o  <= '0;
                     end else begin
                        word_cnt <= word_cnt + 32'd1;
                        state    <= IDLE;
                     end
                  end
               end
               POLL: begin
                  if (resp_fire) begin
                     if (sbcs_fault) begin
                        state <= ERR;
                        err_o <= 1'b1;
                     end else if (sbcs_busy) begin
                        if (poll_cnt + 32'd1 == 32'(PollTimeout)) begin
                           state <= ERR;
                           err_o <= 1'b1;
                        end else begin
                           poll_cnt        <= poll_cnt + 32'd1;
                           dmi_req_valid_o <= 1'b1;
                        end
                     end else begin
                        if (flushing) begin
                           flush_done_o <= 1'b1;
                           word_cnt     <= '0;
                        end
                        flushing <= 1'b0;
                        state    <= IDLE;
                     end
                  end
               end
               ERR: begin
                  if (err_clr_i) begin
                     err_o    <= 1'b0;
                     cfg_done <= 1'b0;
                     word_cnt <= '0;
                     flushing <= 1'b0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmi_sba_loader.sv
// Directed bench for dmi_sba_loader: a small DMI target logs every request and
// answers SBCS reads from a scripted queue.
module tb_dmi_sba_loader;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        wr_valid_i;
   logic        wr_ready_o;
   logic [31:0] wr_addr_i;
   logic [31:0] wr_data_i;
   logic        flush_i;
   logic        flush_done_o;
   logic        err_o;
   logic        err_clr_i;
   logic        dmi_req_valid_o;
   logic        dmi_req_ready_i;
   logic [6:0]  dmi_req_addr_o;
   logic [1:0]  dmi_req_op_o;
   logic [31:0] dmi_req_data_o;
   logic        dmi_resp_valid_i;
   logic        dmi_resp_ready_o;
   logic [31:0] dmi_resp_data_i;
   logic [1:0]  dmi_resp_resp_i;

   int checkCount = 0;
   int errorCount = 0;

   logic [6:0]  logAddr[$];
   logic [1:0]  logOp[$];
   logic [31:0] logData[$];
   logic [31:0] pollQ[$];
   logic [31:0] pollDefault = 32'h0;
   logic [1:0]  respCode = 2'd0;
   logic        respPending = 1'b0;
   logic [31:0] pendData = 32'h0;
   logic [1:0]  pendResp = 2'd0;
   int          stallLeft = 0;
   int          flushDoneCount = 0;

   dmi_sba_loader #(.PollInterval(4), .PollTimeout(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .flush_i(flush_i), .flush_done_o(flush_done_o),
      .err_o(err_o), .err_clr_i(err_clr_i),
      .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
      .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
      .dmi_req_data_o(dmi_req_data_o),
      .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
      .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_resp_i(dmi_resp_resp_i)
   );

   always #5 clk_i = ~clk_i;

   // DMI target, sampling side: records accepted requests and prepares the response
   initial forever begin
      @(posedge clk_i);
      if (rst_ni && dmi_req_valid_o && dmi_req_ready_i) begin
         logAddr.push_back(dmi_req_addr_o);
         logOp.push_back(dmi_req_op_o);
         logData.push_back(dmi_req_data_o);
         respPending = 1'b1;
         pendResp    = respCode;
         respCode    = 2'd0;
         if (dmi_req_op_o == 2'd1)
            pendData = (pollQ.size() > 0) ? pollQ.pop_front() : pollDefault;
         else
            pendData = 32'h0;
      end
      if (flush_done_o) flushDoneCount++;
   end

   // DMI target, driving side: changes its inputs only on falling edges
   initial forever begin
      @(negedge clk_i);
      dmi_resp_valid_i = 1'b0;
      if (respPending && dmi_resp_ready_o) begin
         dmi_resp_valid_i = 1'b1;
         dmi_resp_data_i  = pendData;
         dmi_resp_resp_i  = pendResp;
         respPending      = 1'b0;
      end
      dmi_req_ready_i = 1'b0;
      if (dmi_req_valid_o) begin
         if (stallLeft > 0) stallLeft--;
         else dmi_req_ready_i = 1'b1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic checkEntry(input string tag, input int idx, input logic [6:0] a,
                             input logic [1:0] op, input logic [31:0] d);
      logic [31:0] gotAo;
      logic [31:0] gotD;
      gotAo = 32'hFFFF_FFFF;
      gotD  = 32'hFFFF_FFFF;
      if (idx < logAddr.size()) begin
         gotAo = {23'd0, logAddr[idx], logOp[idx]};
         gotD  = logData[idx];
      end
      checkOutput({tag, "_addr_op"}, gotAo, {23'd0, a, op});
      checkOutput({tag, "_data"}, gotD, d);
   endtask

   task automatic clearLog();
      logAddr.delete();
      logOp.delete();
      logData.delete();
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk_i);
      wr_addr_i  = a;
      wr_data_i  = d;
      wr_valid_i = 1'b1;
      for (int i = 0; i < 400 && !wr_ready_o; i++) @(negedge clk_i);
      checkOutput("wr_accept", {31'd0, wr_ready_o}, 32'd1);
      if (wr_ready_o) begin
         @(posedge clk_i);
         #1;
      end
      wr_valid_i = 1'b0;
   endtask

   task automatic waitReady(input string tag);
      for (int i = 0; i < 400 && !wr_ready_o; i++) @(negedge clk_i);
      checkOutput(tag, {31'd0, wr_ready_o}, 32'd1);
   endtask

   task automatic waitErr(input string tag);
      for (int i = 0; i < 400 && !err_o; i++) @(negedge clk_i);
      checkOutput(tag, {31'd0, err_o}, 32'd1);
   endtask

   task automatic pulseFlush();
      @(negedge clk_i);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1 flush_i = 1'b0;
   endtask

   task automatic pulseErrClr();
      @(negedge clk_i);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ctl"},
                  {26'd0, wr_ready_o, flush_done_o, err_o, dmi_req_valid_o, dmi_resp_ready_o, 1'b0},
                  32'd0);
      checkOutput({tag, "_req_ao"}, {23'd0, dmi_req_addr_o, dmi_req_op_o}, 32'd0);
      checkOutput({tag, "_req_data"}, dmi_req_data_o, 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0; wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
      flush_i = 1'b0; err_clr_i = 1'b0; dmi_req_ready_i = 1'b0;
      dmi_resp_valid_i = 1'b0; dmi_resp_data_i = '0; dmi_resp_resp_i = '0;
      repeat (3) @(negedge clk_i);
      checkResetOutputs("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);
      checkOutput("ready_after_reset", {31'd0, wr_ready_o}, 32'd1);

      // First write: config, address, data
      applyStimulus(32'h0100_0000, 32'hDEAD_BEEF);
      waitReady("w1_done");
      checkOutput("w1_count", logAddr.size(), 3);
      checkEntry("w1_sbcs", 0, 7'h38, 2'd2, 32'h0005_0000);
      checkEntry("w1_addr", 1, 7'h39, 2'd2, 32'h0100_0000);
      checkEntry("w1_data", 2, 7'h3C, 2'd2, 32'hDEAD_BEEF);
      clearLog();

      applyStimulus(32'h0100_0004, 32'h1111_1111);
      waitReady("w2_done");
      checkOutput("w2_count", logAddr.size(), 1);
      checkEntry("w2_data", 0, 7'h3C, 2'd2, 32'h1111_1111);
      clearLog();

      applyStimulus(32'h0200_0000, 32'h2222_2222);
      waitReady("w3_done");
      checkOutput("w3_count", logAddr.size(), 2);
      checkEntry("w3_addr", 0, 7'h39, 2'd2, 32'h0200_0000);
      checkEntry("w3_data", 1, 7'h3C, 2'd2, 32'h2222_2222);
      clearLog();

      // Fourth word reaches the poll interval: one idle SBCS read follows
      applyStimulus(32'h0200_0004, 32'h3333_3333);
      waitReady("w4_done");
      checkOutput("w4_count", logAddr.size(), 2);
      checkEntry("w4_poll", 1, 7'h38, 2'd1, 32'h0);
      clearLog();

      // Four contiguous words, SBCS busy twice then idle
      pollQ.push_back(32'h0020_0000);
      pollQ.push_back(32'h0020_0000);
      pollQ.push_back(32'h0000_0000);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'h0200_0008 + 32'(4 * i), 32'hA000_0000 + 32'(i));
         waitReady("contig_done");
      end
      checkOutput("contig_count", logAddr.size(), 7);
      checkEntry("contig_d3", 3, 7'h3C, 2'd2, 32'hA000_0003);
      checkEntry("contig_p1", 4, 7'h38, 2'd1, 32'h0);
      checkEntry("contig_p3", 6, 7'h38, 2'd1, 32'h0);
      clearLog();

      // Flush with sberror reported, with a write competing for priority
      pollQ.push_back(32'h0000_1000);
      flushDoneCount = 0;
      @(negedge clk_i);
      flush_i    = 1'b1;
      wr_valid_i = 1'b1;
      wr_addr_i  = 32'h0500_0000;
      #1 checkOutput("flush_blocks_ready", {31'd0, wr_ready_o}, 32'd0);
      @(posedge clk_i);
      #1 flush_i = 1'b0;
      wr_valid_i = 1'b0;
      waitErr("flush_sberr");
      checkOutput("flush_sberr_log", logAddr.size(), 1);
      checkEntry("flush_sberr_rd", 0, 7'h38, 2'd1, 32'h0);
      checkOutput("flush_sberr_nodone", flushDoneCount, 0);
      checkOutput("err_blocks_ready", {31'd0, wr_ready_o}, 32'd0);
      pulseErrClr();
      checkOutput("err_cleared", {31'd0, err_o}, 32'd0);
      checkOutput("ready_after_clr", {31'd0, wr_ready_o}, 32'd1);
      clearLog();

      applyStimulus(32'h0200_0018, 32'h5555_5555);
      waitReady("reconfig_done");
      checkOutput("reconfig_count", logAddr.size(), 3);
      checkEntry("reconfig_sbcs", 0, 7'h38, 2'd2, 32'h0005_0000);
      clearLog();

      // err_clr_i outside ERR must not drop the configuration
      pulseErrClr();
      applyStimulus(32'h0200_001C, 32'h6666_6666);
      waitReady("clr_idle_done");
      checkOutput("clr_idle_count", logAddr.size(), 1);
      checkEntry("clr_idle_data", 0, 7'h3C, 2'd2, 32'h6666_6666);
      clearLog();

      // Successful flush pulses done once and restarts the word count
      flushDoneCount = 0;
      pulseFlush();
      waitReady("flush_ok_done");
      @(negedge clk_i);
      checkOutput("flush_ok_pulses", flushDoneCount, 1);
      checkOutput("flush_ok_log", logAddr.size(), 1);
      clearLog();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h0200_0020 + 32'(4 * i), 32'hB000_0000 + 32'(i));
         waitReady("post_flush_done");
      end
      checkOutput("post_flush_no_poll", logAddr.size(), 3);
      clearLog();

      // Error response code on a data write
      respCode = 2'd2;
      applyStimulus(32'h0200_002C, 32'h7777_7777);
      waitErr("resp_err");
      checkOutput("resp_err_log", logAddr.size(), 1);
      pulseErrClr();
      clearLog();

      // SBCS stays busy: poll gives up after the timeout
      pollDefault = 32'h0020_0000;
      pulseFlush();
      waitErr("timeout_err");
      repeat (4) @(negedge clk_i);
      checkOutput("timeout_reads", logAddr.size(), 8);
      checkEntry("timeout_last", 7, 7'h38, 2'd1, 32'h0);
      pollDefault = 32'h0;
      pulseErrClr();
      clearLog();

      // Stall the data request, then reset in the middle of it
      applyStimulus(32'h0300_0000, 32'h8888_8888);
      waitReady("pre_stall_done");
      clearLog();
      stallLeft = 1000;
      applyStimulus(32'h0300_0004, 32'h4444_4444);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         checkOutput("stall_valid", {31'd0, dmi_req_valid_o}, 32'd1);
         checkOutput("stall_ao", {23'd0, dmi_req_addr_o, dmi_req_op_o}, {23'd0, 7'h3C, 2'd2});
         checkOutput("stall_data", dmi_req_data_o, 32'h4444_4444);
      end
      rst_ni = 1'b0;
      #1 checkResetOutputs("mid_reset");
      @(negedge clk_i);
      stallLeft   = 0;
      respPending = 1'b0;
      rst_ni      = 1'b1;
      @(negedge clk_i);
      checkOutput("ready_after_mid_reset", {31'd0, wr_ready_o}, 32'd1);
      repeat (4) @(negedge clk_i);
      checkOutput("no_req_after_reset",
                  {30'd0, dmi_req_valid_o, dmi_resp_ready_o}, 32'd0);
      checkOutput("stall_log_empty", logAddr.size(), 0);
      applyStimulus(32'h0300_0008, 32'h9999_9999);
      waitReady("post_reset_done");
      checkOutput("post_reset_count", logAddr.size(), 3);
      checkEntry("post_reset_sbcs", 0, 7'h38, 2'd2, 32'h0005_0000);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/dmi_sba_loader.md
DMI_SBA_LOADER -- requirements
Module: dmi_sba_loader

Interface
REQ-001 SHALL have parameter PollInterval, default 128: number of SBData0 writes between sbbusy checks (>=1).
REQ-002 SHALL have parameter PollTimeout, default 1024: maximum consecutive busy SBCS reads before error.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports wr_valid_i input 1 / wr_ready_o output 1: word-write request handshake.
REQ-006 SHALL have ports wr_addr_i input 32 / wr_data_i input 32: target address (word-aligned) and data.
REQ-007 SHALL have ports flush_i input 1 (request drain check) / flush_done_o output 1 (one-cycle completion pulse).
REQ-008 SHALL have ports err_o output 1 (sticky error) / err_clr_i input 1 (error clear).
REQ-009 SHALL have ports dmi_req_valid_o output 1, dmi_req_ready_i input 1, dmi_req_addr_o output 7, dmi_req_op_o output 2, dmi_req_data_o output 32.
REQ-010 SHALL have ports dmi_resp_valid_i input 1, dmi_resp_ready_o output 1, dmi_resp_data_i input 32, dmi_resp_resp_i input 2.

Function
REQ-011 SHALL implement states IDLE, CFG, ADDR, DATA, POLL, ERR; each non-IDLE/ERR state issues exactly one DMI transaction, then waits for its response.
REQ-012 SHALL assert wr_ready_o only in IDLE with err_o=0 and flush_i=0; flush_i has priority over wr_valid_i.
REQ-013 On accepted write, SHALL capture addr/data; next state CFG if cfg_done=0, DATA if wr_addr_i equals expected_addr, else ADDR.
REQ-014 CFG SHALL write SBCS (addr 0x38, op 2) data 0x0005_0000 (sbaccess=2, sbautoincrement=1), set cfg_done, go ADDR.
REQ-015 ADDR SHALL write SBAddress0 (0x39, op 2) with captured address, then go DATA.
REQ-016 DATA SHALL write SBData0 (0x3C, op 2) with captured data; on completion expected_addr = captured addr + 4 (mod 2^32) and word counter increments.
REQ-017 After DATA, SHALL go POLL when word counter reaches PollInterval (counter cleared), else IDLE.
REQ-018 POLL SHALL read SBCS (0x38, op 1, data 0); resp bit22 (sbbusyerror) or bits[14:12] (sberror) nonzero -> ERR; bit21 (sbbusy) set -> reissue read; else done.
REQ-019 POLL busy-retry counter SHALL increment per busy response; reaching PollTimeout -> ERR; counter clears on POLL entry.
REQ-020 In IDLE with flush_i=1, SHALL go POLL; on successful POLL completion pulse flush_done_o for one cycle, clear word counter, return IDLE.
REQ-021 DMI request: dmi_req_valid_o held with stable addr/op/data until dmi_req_ready_i sampled high; then deasserted next cycle.
REQ-022 dmi_resp_ready_o SHALL be 1 only while awaiting a response; one request outstanding at most.
REQ-023 Any response with dmi_resp_resp_i != 0 SHALL go ERR.
REQ-024 ERR SHALL set err_o=1, drive no DMI requests; err_clr_i in ERR clears err_o, cfg_done, word counter, goes IDLE next cycle.
REQ-025 err_clr_i outside ERR SHALL have no effect.

Reset
REQ-026 On rst_ni=0 SHALL immediately go IDLE, clear cfg_done, expected_addr, counters; outputs wr_ready_o=0 (1 after release once IDLE), flush_done_o=0, err_o=0, dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_req_* =0.
REQ-027 Reset mid-transaction SHALL abandon it; no response is awaited after release.

Verification
REQ-028 First write addr 0x0100_0000 data 0xDEAD_BEEF -> DMI writes SBCS=0x0005_0000, SBAddress0=0x0100_0000, SBData0=0xDEADBEEF in order.
REQ-029 Next write addr 0x0100_0004 -> only SBData0 write; then addr 0x0200_0000 -> SBAddress0 then SBData0.
REQ-030 PollInterval=4, 4 contiguous writes, SBCS read returns bit21 twice then 0 -> three SBCS reads, then wr_ready_o=1.
REQ-031 flush_i in IDLE, SBCS returns 0x0000_1000 -> err_o=1, no flush_done_o; err_clr_i -> IDLE, next write reissues SBCS config.
REQ-032 PollTimeout=8, SBCS always busy -> exactly 8 reads, then err_o=1.
REQ-033 dmi_req_ready_i held low 5 cycles, rst_ni pulsed mid-DATA -> request fields stable while stalled; after reset all outputs at reset values.
